// File: rtl/pixel_gap_filler_if.sv
// SRAM port bundle between the gap filler (master) and the frame buffer (slave).
interface pixel_gap_filler_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18
);
    logic                  wren;
    logic [DATA_WIDTH-1:0] data_write;
    logic [DATA_WIDTH-1:0] data_read;
    logic [ADDR_WIDTH-1:0] address;

    modport master (output wren, data_write, address, input data_read);
    modport slave  (input wren, data_write, address, output data_read);
endinterface

// File: rtl/pixel_gap_filler.sv
// In-place frame scan that sets a pixel to FILL_VALUE when both neighbours on the
// selected axis (Y, X or either) already hold FILL_VALUE.
module pixel_gap_filler #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 18,
    parameter int unsigned           IMG_WIDTH  = 320,
    parameter int unsigned           IMG_HEIGHT = 240,
    parameter int unsigned           MARGIN     = 7,
    parameter int unsigned           MODE       = 0,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(1),
    parameter int unsigned           WRITE_ALL  = 1
) (
    input  logic                 clk_div_by_two,
    input  logic                 reset,
    input  logic                 pause,
    input  logic                 enable,
    pixel_gap_filler_if.master   bus,
    output logic                 done
);
    localparam int unsigned NREADS    = (MODE == 2) ? 5 : 3;
    localparam int unsigned COL_FIRST = (MODE == 0) ? 0 : 1;
    localparam int unsigned COL_LAST  = (MODE == 0) ? IMG_WIDTH - 1 : IMG_WIDTH - 2;
    localparam int unsigned COL_W     = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned PH_W      = 3;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(MARGIN * IMG_WIDTH + COL_FIRST);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  =
        ADDR_WIDTH'((IMG_HEIGHT - 1 - MARGIN) * IMG_WIDTH + COL_LAST);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WRAP_STEP  = ADDR_WIDTH'(COL_FIRST + IMG_WIDTH - COL_LAST);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [COL_W-1:0]      COL_FIRST_C = COL_W'(COL_FIRST);
    localparam logic [COL_W-1:0]      COL_LAST_C  = COL_W'(COL_LAST);
    localparam logic [PH_W-1:0]       LAST_ISSUE  = PH_W'(NREADS - 1);
    localparam logic [PH_W-1:0]       LAST_CAP    = PH_W'(NREADS);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                state, state_n;
    logic [PH_W-1:0]       ph, ph_n;
    logic [COL_W-1:0]      col, col_n;
    logic [ADDR_WIDTH-1:0] c_addr, c_addr_n;
    logic [DATA_WIDTH-1:0] c_val, c_val_n;
    logic [3:0]            nb_eq, nb_n, nb_now;
    logic                  wren_q, wren_n, done_q, done_n;
    logic [DATA_WIDTH-1:0] data_write_q, data_write_n;
    logic [ADDR_WIDTH-1:0] address_q, address_n;
    logic [1:0]            slot;
    logic                  pair_v, pair_h, fill;
    logic [DATA_WIDTH-1:0] result;

    assign bus.wren       = wren_q;
    assign bus.data_write = data_write_q;
    assign bus.address    = address_q;
    assign done           = done_q;

    // Read index 1.. maps to neighbour A,B (Y) / L,R (X) / A,B,L,R (BOTH)
    function automatic logic [ADDR_WIDTH-1:0] nb_addr(input logic [ADDR_WIDTH-1:0] c,
                                                      input logic [PH_W-1:0]       idx);
        logic [ADDR_WIDTH-1:0] a;
        a = c;
        if (MODE == 1) begin
            case (idx)
                PH_W'(1): a = c - ONE;
                PH_W'(2): a = c + ONE;
                default:  a = c;
            endcase
        end else begin
            case (idx)
                PH_W'(1): a = c - ROW_STEP;
                PH_W'(2): a = c + ROW_STEP;
                PH_W'(3): a = c - ONE;
                PH_W'(4): a = c + ONE;
                default:  a = c;
            endcase
        end
        return a;
    endfunction

    // Neighbour equality bits: slots 0/1 vertical pair, 2/3 horizontal pair
    always_comb begin
        slot   = (MODE == 1) ? 2'(ph) : 2'(ph - PH_W'(2));
        nb_now = nb_eq;
        if (state == S_READ && ph >= PH_W'(2)) begin
            nb_now[slot] = (bus.data_read == FILL_VALUE);
        end
        pair_v = nb_now[0] & nb_now[1];
        pair_h = nb_now[2] & nb_now[3];
        fill   = (MODE == 0) ? pair_v : ((MODE == 1) ? pair_h : (pair_v | pair_h));
        result = fill ? FILL_VALUE : c_val;
    end

    always_comb begin
        state_n      = state;
        ph_n         = ph;
        col_n        = col;
        c_addr_n     = c_addr;
        c_val_n      = c_val;
        nb_n         = nb_eq;
        wren_n       = wren_q;
        data_write_n = data_write_q;
        address_n    = address_q;
        done_n       = done_q;
        case (state)
            S_IDLE: begin
                if (!done_q) begin
                    state_n   = S_READ;
                    ph_n      = '0;
                    col_n     = COL_FIRST_C;
                    c_addr_n  = FIRST_ADDR;
                    address_n = FIRST_ADDR;
                    nb_n      = '0;
                    wren_n    = 1'b0;
                end
            end
            S_READ: begin
                // Reads issue one per edge; captures trail their issue by two edges
                ph_n = ph + PH_W'(1);
                if (ph == PH_W'(1)) c_val_n = bus.data_read;
                if (ph >= PH_W'(2)) nb_n = nb_now;
                if (ph < LAST_ISSUE) address_n = nb_addr(c_addr, ph + PH_W'(1));
                if (ph == LAST_CAP) begin
                    state_n      = S_WRITE;
                    address_n    = c_addr;
                    data_write_n = result;
                    wren_n       = (WRITE_ALL != 0) || (result != c_val);
                end
            end
            S_WRITE: begin
                wren_n = 1'b0;
                if (c_addr == LAST_ADDR) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n   = S_READ;
                    ph_n      = '0;
                    nb_n      = '0;
                    col_n     = (col == COL_LAST_C) ? COL_FIRST_C : col + COL_W'(1);
                    c_addr_n  = c_addr + ((col == COL_LAST_C) ? WRAP_STEP : ONE);
                    address_n = c_addr + ((col == COL_LAST_C) ? WRAP_STEP : ONE);
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Reset and a low enable both abort; pause freezes everything else
    always_ff @(posedge clk_div_by_two) begin
        if (reset || !enable) begin
            state        <= S_IDLE;
            ph           <= '0;
            col          <= '0;
            c_addr       <= '0;
            c_val        <= '0;
            nb_eq        <= '0;
            wren_q       <= 1'b0;
            data_write_q <= '0;
            address_q    <= '0;
            done_q       <= 1'b0;
        end else if (!pause) begin
            state        <= state_n;
            ph           <= ph_n;
            col          <= col_n;
            c_addr       <= c_addr_n;
            c_val        <= c_val_n;
            nb_eq        <= nb_n;
            wren_q       <= wren_n;
            data_write_q <= data_write_n;
            address_q    <= address_n;
            done_q       <= done_n;
        end
    end
endmodule

// File: tb/tb_pixel_gap_filler.sv
// Directed bench for pixel_gap_filler on an 8x8 frame: four instances cover Y/WRITE_ALL,
// Y, X/changed-only and BOTH/changed-only, each with its own write-first SRAM model.
module tb_pixel_gap_filler;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 18;
    localparam int unsigned NPIX = 64;
    localparam int NV = 7;

    typedef struct {
        int          k;
        logic [63:0] init;
        logic [63:0] expect_img;
        int          lat;
        int          wr;
        int          first;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, pause;
    logic          en      [4];
    logic          done_s  [4];
    logic          wren_s  [4];
    logic [AW-1:0] addr_s  [4];
    logic [DW-1:0] wd_s    [4];
    logic [DW-1:0] rd_s    [4];
    logic [DW-1:0] mem     [4][NPIX];
    logic          load    [4];
    logic [63:0]   img;
    int            wcnt    [4];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    vec_t          vecs    [NV];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned M  = (g == 2) ? 1 : ((g == 3) ? 2 : 0);
        localparam int unsigned WA = (g >= 2) ? 0 : 1;
        pixel_gap_filler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        pixel_gap_filler #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(8), .IMG_HEIGHT(8), .MARGIN(1),
            .MODE(M), .FILL_VALUE(32'd1), .WRITE_ALL(WA)
        ) dut (
            .clk_div_by_two(clk), .reset(rst), .pause(pause), .enable(en[g]),
            .bus(bus), .done(done_s[g])
        );
        assign bus.data_read = rd_s[g];
        assign wren_s[g]     = bus.wren;
        assign addr_s[g]     = bus.address;
        assign wd_s[g]       = bus.data_write;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first synchronous SRAM models plus write-pulse counters
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
                for (int j = 0; j < int'(NPIX); j++) mem[k][j] <= {{(DW-1){1'b0}}, img[j]};
                wcnt[k] <= 0;
            end else if (wren_s[k]) begin
                mem[k][addr_s[k][5:0]] <= wd_s[k];
                wcnt[k] <= wcnt[k] + 1;
            end
            rd_s[k] <= wren_s[k] ? wd_s[k] : mem[k][addr_s[k][5:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_mask(input int k);
        logic [63:0] m;
        for (int j = 0; j < int'(NPIX); j++) m[j] = (mem[k][j] == 32'd1);
        return m;
    endfunction

    function automatic logic [63:0] bits2(input int a, input int b);
        return (64'd1 << a) | (64'd1 << b);
    endfunction

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_scan(input string tag, input int k, input logic [63:0] init,
                              input int first, output int e0);
        @(negedge clk);
        en[k]   = 1'b0;
        img     = init;
        load[k] = 1'b1;
        @(negedge clk);
        load[k] = 1'b0;
        chk({tag, "_idle_wren"}, 64'(wren_s[k]), 64'd0);
        chk({tag, "_idle_addr"}, 64'(addr_s[k]), 64'd0);
        chk({tag, "_idle_done"}, 64'(done_s[k]), 64'd0);
        en[k] = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        chk({tag, "_first_addr"}, 64'(addr_s[k]), 64'(first));
    endtask

    task automatic wait_done(input int k, input int e0, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_s[k]) begin
                seen = 1'b1;
                lat  = cyc - e0;
            end
        end
    endtask

    initial begin
        int e0, lat;
        logic [63:0] m1;
        string tag;
        rst   = 1'b1;
        pause = 1'b0;
        img   = '0;
        for (int k = 0; k < 4; k++) begin
            en[k]   = 1'b0;
            load[k] = 1'b0;
        end
        m1 = bits2(19, 35) | (64'd1 << 27);
        vecs[0] = '{0, bits2(19, 35), m1, 240, 48, 8};
        vecs[1] = '{1, bits2(19, 43), bits2(19, 43), 240, 48, 8};
        vecs[2] = '{2, bits2(26, 28), bits2(26, 28) | (64'd1 << 27), 180, 1, 9};
        vecs[3] = '{3, bits2(19, 35) | bits2(43, 45),
                    bits2(19, 35) | bits2(43, 45) | bits2(27, 44), 252, 2, 9};
        vecs[4] = '{0, bits2(3, 19), bits2(3, 19) | (64'd1 << 11), 240, 48, 8};
        vecs[5] = '{2, bits2(8, 10), bits2(8, 10) | (64'd1 << 9), 180, 1, 9};
        vecs[6] = '{2, bits2(14, 16), bits2(14, 16), 180, 0, 9};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst%0d_wren", k), 64'(wren_s[k]), 64'd0);
            chk($sformatf("rst%0d_addr", k), 64'(addr_s[k]), 64'd0);
            chk($sformatf("rst%0d_data", k), 64'(wd_s[k]), 64'd0);
            chk($sformatf("rst%0d_done", k), 64'(done_s[k]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            tag = $sformatf("v%0d", v);
            start_scan(tag, vecs[v].k, vecs[v].init, vecs[v].first, e0);
            wait_done(vecs[v].k, e0, lat);
            chk({tag, "_latency"}, 64'(lat), 64'(vecs[v].wr >= 0 ? vecs[v].lat : 0));
            chk({tag, "_wren_pulses"}, 64'(wcnt[vecs[v].k]), 64'(vecs[v].wr));
            chk({tag, "_image"}, mem_mask(vecs[v].k), vecs[v].expect_img);
            @(negedge clk);
            en[vecs[v].k] = 1'b0;
        end

        // Pause across the write of pixel 12 (address 20): outputs must freeze
        start_scan("pause", 0, bits2(19, 35), 8, e0);
        wait_until(e0 + 64);
        chk("pause_pre_wren", 64'(wren_s[0]), 64'd1);
        chk("pause_pre_addr", 64'(addr_s[0]), 64'd20);
        @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("pause_hold%0d_wren", i), 64'(wren_s[0]), 64'd1);
            chk($sformatf("pause_hold%0d_addr", i), 64'(addr_s[0]), 64'd20);
            chk($sformatf("pause_hold%0d_data", i), 64'(wd_s[0]), 64'd0);
        end
        @(negedge clk);
        pause = 1'b0;
        wait_done(0, e0, lat);
        chk("pause_latency", 64'(lat), 64'd250);
        chk("pause_image", mem_mask(0), m1);

        // Abort at E0+100, then restart from the first pixel
        start_scan("abort", 0, bits2(19, 35), 8, e0);
        wait_until(e0 + 99);
        @(negedge clk);
        en[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_wren", 64'(wren_s[0]), 64'd0);
        chk("abort_addr", 64'(addr_s[0]), 64'd0);
        chk("abort_data", 64'(wd_s[0]), 64'd0);
        chk("abort_done", 64'(done_s[0]), 64'd0);
        @(negedge clk);
        en[0] = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        chk("abort_restart_addr", 64'(addr_s[0]), 64'd8);
        wait_done(0, e0, lat);
        chk("abort_latency", 64'(lat), 64'd240);
        chk("abort_wren_pulses", 64'(wcnt[0]), 64'd68);
        chk("abort_image", mem_mask(0), m1);
        @(negedge clk);
        en[0] = 1'b0;

        // Reset pulse at E0+50 with enable held high
        start_scan("reset", 0, bits2(19, 35), 8, e0);
        wait_until(e0 + 49);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_wren", 64'(wren_s[0]), 64'd0);
        chk("reset_addr", 64'(addr_s[0]), 64'd0);
        chk("reset_done", 64'(done_s[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        e0 = cyc;
        chk("reset_restart_addr", 64'(addr_s[0]), 64'd8);
        wait_done(0, e0, lat);
        chk("reset_latency", 64'(lat), 64'd240);
        chk("reset_image", mem_mask(0), m1);
        @(negedge clk);
        en[0] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
